// File: rtl/morse_key_timer.sv
// morse_key_timer: straight-key front end for the Morse decoder.
// Synchronizes (and optionally debounces) the raw key, times marks and gaps in
// Morse units and emits single-cycle dot/dash/char-space/word-space pulses whose
// spacing respects the downstream decoder's guard intervals.
// Optional feature macro: MORSE_KEY_DEBOUNCE_EN (debouncer present when defined).
module morse_key_timer #(
    parameter int unsigned UNIT_CYCLES     = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic dot_inp,
    output logic dash_inp,
    output logic char_space_inp,
    output logic word_space_inp,
    output logic err_long,
    output logic key_db
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StMark    = 3'd1;
    localparam logic [2:0] StGap     = 3'd2;
    localparam logic [2:0] StGapChar = 3'd3;
    localparam logic [2:0] StLong    = 3'd4;

    logic       sync1_q, sync2_q, key_s;
    logic       key_lvl, key_prev_q, key_rise, key_fall, key_edge;
    logic [11:0] pres_q, pres_d;
    logic       wrap;
    logic [3:0] unit_q, unit_d;
    logic [2:0] state_q, state_d;
    logic [2:0] guard_q, guard_d;
    logic       pend_valid_q, pend_valid_d, pend_dash_q, pend_dash_d;
    logic       sym_new, sym_new_dash, sym_avail, sym_dash, sym_fire;
    logic       char_fire, word_fire, err_fire;
    logic       dot_q, dash_q, char_q, word_q, err_q;

    // Two-flop synchronizer for the asynchronous key input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end
    assign key_s = sync2_q;

`ifdef MORSE_KEY_DEBOUNCE_EN
    logic [7:0] db_cnt_q, db_cnt_d;
    logic       key_db_q, key_db_d;

    // Accept a level change only once it has persisted DEBOUNCE_CYCLES samples
    always_comb begin
        db_cnt_d = 8'd0;
        key_db_d = key_db_q;
        if (key_s != key_db_q) begin
            if (db_cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
                key_db_d = key_s;
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q <= 8'd0;
            key_db_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            key_db_q <= key_db_d;
        end
    end
    assign key_lvl = key_db_q;
`else
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
    assign key_lvl = key_s;
`endif

    assign key_rise = key_lvl & ~key_prev_q;
    assign key_fall = ~key_lvl & key_prev_q;
    assign key_edge = key_rise | key_fall;
    assign wrap     = (pres_q == 12'(UNIT_CYCLES - 1));

    // Unit timer: key edges restart the prescaler and clear the unit count
    always_comb begin
        pres_d = pres_q + 12'd1;
        unit_d = unit_q;
        if (key_edge) begin
            pres_d = 12'd0;
            unit_d = 4'd0;
        end else if (wrap) begin
            pres_d = 12'd0;
            if (unit_q != 4'd15) begin
                unit_d = unit_q + 4'd1;
            end
        end
    end

    // Mark/gap FSM; ">= N or about to wrap into N" lets a deferred gap pulse fire later
    always_comb begin
        state_d      = state_q;
        sym_new      = 1'b0;
        sym_new_dash = 1'b0;
        char_fire    = 1'b0;
        word_fire    = 1'b0;
        err_fire     = 1'b0;
        case (state_q)
            StIdle: begin
                if (key_rise) state_d = StMark;
            end
            StMark: begin
                if (key_fall) begin
                    sym_new      = 1'b1;
                    sym_new_dash = (unit_q >= 4'd2);
                    state_d      = StGap;
                end else if ((unit_q == 4'd15 || (wrap && unit_q == 4'd14)) && !pend_valid_q) begin
                    err_fire = 1'b1;
                    state_d  = StLong;
                end
            end
            StLong: begin
                if (key_fall) state_d = StIdle;
            end
            StGap: begin
                if (key_rise) begin
                    state_d = StMark;
                end else if ((unit_q >= 4'd3 || (wrap && unit_q == 4'd2)) && !pend_valid_q) begin
                    char_fire = 1'b1;
                    state_d   = StGapChar;
                end
            end
            StGapChar: begin
                if (key_rise) begin
                    state_d = StMark;
                end else if ((unit_q >= 4'd7 || (wrap && unit_q == 4'd6)) && !pend_valid_q) begin
                    word_fire = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Symbol release: hold a classified symbol until the guard interval expires
    always_comb begin
        sym_avail    = pend_valid_q | sym_new;
        sym_dash     = pend_valid_q ? pend_dash_q : sym_new_dash;
        sym_fire     = sym_avail && (guard_q == 3'd0);
        pend_valid_d = sym_avail && !sym_fire;
        pend_dash_d  = sym_dash;
        if (word_fire) begin
            guard_d = 3'd7;
        end else if (char_fire) begin
            guard_d = 3'd3;
        end else if (guard_q != 3'd0) begin
            guard_d = guard_q - 3'd1;
        end else begin
            guard_d = 3'd0;
        end
    end

    // Timer, FSM, guard and registered pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_prev_q   <= 1'b0;
            pres_q       <= 12'd0;
            unit_q       <= 4'd0;
            state_q      <= StIdle;
            guard_q      <= 3'd0;
            pend_valid_q <= 1'b0;
            pend_dash_q  <= 1'b0;
            dot_q        <= 1'b0;
            dash_q       <= 1'b0;
            char_q       <= 1'b0;
            word_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            key_prev_q   <= key_lvl;
            pres_q       <= pres_d;
            unit_q       <= unit_d;
            state_q      <= state_d;
            guard_q      <= guard_d;
            pend_valid_q <= pend_valid_d;
            pend_dash_q  <= pend_dash_d;
            dot_q        <= sym_fire & ~sym_dash;
            dash_q       <= sym_fire & sym_dash;
            char_q       <= char_fire;
            word_q       <= word_fire;
            err_q        <= err_fire & ~sym_fire;
        end
    end

    assign dot_inp        = dot_q;
    assign dash_inp       = dash_q;
    assign char_space_inp = char_q;
    assign word_space_inp = word_q;
    assign err_long       = err_q;
    assign key_db         = key_lvl;

endmodule
